// File: rtl/johnson_monitor.sv
// -----------------------------------------------------------------------------
// johnson_monitor
//
// Downstream checker for a WIDTH-bit Johnson (twisted-ring) counter. Each
// enabled clock edge samples the counter word, decodes it into a one-hot and
// a binary phase, and checks it twice:
//   - code check : the word must be one of the 2*WIDTH legal Johnson states;
//   - step check : when the previous enabled sample was legal, the word must
//                  equal the previous word shifted right with the inverted
//                  LSB fed into the MSB.
// A small lock state machine declares the counter trustworthy after
// LOCK_CYCLES consecutive good checked steps. Any error drops lock at once.
// A sticky flag and a saturating counter record errors until clr_err.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   asynchronous active-low reset
//   en           in   sample enable; q_in is only looked at when en=1
//   q_in         in   [WIDTH]         Johnson counter word
//   clr_err      in   synchronous clear of err_sticky / err_count
//   phase_onehot out  [2*WIDTH]       registered one-hot decoded phase
//   phase_idx    out  [clog2(2*WIDTH)] registered binary phase index
//   phase_valid  out  last enabled sample was a legal code
//   wrap_pulse   out  one-cycle pulse on a checked legal step last->0
//   locked       out  lock state machine is in LOCKED
//   err_pulse    out  one-cycle pulse on any detected error
//   err_sticky   out  set on error, held until clr_err
//   err_count    out  [ERR_CNT_W]     saturating error count
// -----------------------------------------------------------------------------
module johnson_monitor #(
    parameter int WIDTH       = 4,
    parameter int LOCK_CYCLES = 8,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [WIDTH-1:0]              q_in,
    input  logic                          clr_err,
    output logic [2*WIDTH-1:0]            phase_onehot,
    output logic [$clog2(2*WIDTH)-1:0]    phase_idx,
    output logic                          phase_valid,
    output logic                          wrap_pulse,
    output logic                          locked,
    output logic                          err_pulse,
    output logic                          err_sticky,
    output logic [ERR_CNT_W-1:0]          err_count
);

    localparam int NPH   = 2 * WIDTH;
    localparam int IDX_W = $clog2(NPH);
    // LOCK_CYCLES is limited to 1..255, so an 8-bit run counter always fits.
    localparam int RUN_W = 8;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    // -------------------------------------------------------------------------
    // Johnson code for phase index k.
    //   k in 0..WIDTH      : k ones packed at the MSB end
    //   k in WIDTH+1..NPH-1: (NPH-k) ones packed at the LSB end
    // -------------------------------------------------------------------------
    function automatic logic [WIDTH-1:0] johnson_code(input int k);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int b = 0; b < WIDTH; b++) begin
            if (k <= WIDTH) begin
                c[b] = (b >= WIDTH - k);
            end else begin
                c[b] = (b < NPH - k);
            end
        end
        return c;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]     prev_q;
    logic                 prev_ok;
    logic [RUN_W-1:0]     run_q;
    logic [RUN_W-1:0]     run_d;
    lock_state_e          state_q;
    lock_state_e          state_d;

    // -------------------------------------------------------------------------
    // Decode of the current sample
    // -------------------------------------------------------------------------
    logic                 dec_legal;
    logic [IDX_W-1:0]     dec_idx;
    logic [NPH-1:0]       dec_onehot;

    // NOTE: every signal driven here gets a default before the loop; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        dec_legal  = 1'b0;
        dec_idx    = '0;
        dec_onehot = '0;
        for (int k = 0; k < NPH; k++) begin
            if (q_in == johnson_code(k)) begin
                dec_legal     = 1'b1;
                dec_idx       = IDX_W'(k);
                dec_onehot[k] = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Step check against the previous legal sample
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0]     exp_q;
    logic                 checked;
    logic                 step_err;
    logic                 err;
    logic                 good_step;
    logic                 wrap;

    // The Johnson sequence never maps a state onto itself, so a stall
    // (repeated word) is caught by the same mismatch compare.
    assign exp_q     = {~prev_q[0], prev_q[WIDTH-1:1]};
    assign checked   = en && prev_ok;
    assign step_err  = checked && (q_in != exp_q);
    assign err       = en && (!dec_legal || step_err);
    assign good_step = checked && dec_legal && !step_err;
    // A correct step landing on index 0 can only have come from the last
    // index, so this is exactly the wrap-around step.
    assign wrap      = good_step && (dec_idx == '0);

    // -------------------------------------------------------------------------
    // Lock state machine: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        case (state_q)
            SEARCH: begin
                if (err) begin
                    run_d = '0;
                end else if (good_step) begin
                    if (run_q >= RUN_W'(LOCK_CYCLES - 1)) begin
                        state_d = LOCKED;
                        run_d   = RUN_W'(LOCK_CYCLES);
                    end else begin
                        run_d = run_q + RUN_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (err) begin
                    state_d = SEARCH;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = SEARCH;
                run_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Error bookkeeping: an error on the same edge as clr_err wins, leaving
    // the flag set and the count at one.
    // -------------------------------------------------------------------------
    logic                 sticky_d;
    logic [ERR_CNT_W-1:0] count_d;

    always_comb begin
        sticky_d = err_sticky;
        count_d  = err_count;
        if (err) begin
            sticky_d = 1'b1;
            if (clr_err) begin
                count_d = ERR_CNT_W'(1);
            end else if (err_count != '1) begin
                count_d = err_count + ERR_CNT_W'(1);
            end
        end else if (clr_err) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_onehot <= '0;
            phase_idx    <= '0;
            phase_valid  <= 1'b0;
            wrap_pulse   <= 1'b0;
            err_pulse    <= 1'b0;
            err_sticky   <= 1'b0;
            err_count    <= '0;
            prev_q       <= '0;
            prev_ok      <= 1'b0;
            run_q        <= '0;
            state_q      <= SEARCH;
        end else begin
            // Pulses are already qualified by en inside wrap/err.
            wrap_pulse <= wrap;
            err_pulse  <= err;
            err_sticky <= sticky_d;
            err_count  <= count_d;
            run_q      <= run_d;
            state_q    <= state_d;
            if (en) begin
                phase_onehot <= dec_onehot;
                phase_valid  <= dec_legal;
                if (dec_legal) begin
                    phase_idx <= dec_idx;
                end
                prev_q  <= q_in;
                prev_ok <= dec_legal;
            end else begin
                // A gap breaks the step chain: the next sample is only
                // code-checked, prev_q is kept for visibility.
                prev_ok <= 1'b0;
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule

// File: tb/tb_johnson_monitor.sv
// -----------------------------------------------------------------------------
// tb_johnson_monitor
//
// Self-checking bench for johnson_monitor (WIDTH=4, LOCK_CYCLES=8,
// ERR_CNT_W=8). A behavioural model tracks the monitor in terms of phase
// indices (legal codes are looked up in a table, a good step is "index + 1
// mod 8") and every cycle is compared against it. A stimulus table covers the
// clean start-up sequence; hand-written sequences cover errors, gaps,
// saturation, clear and asynchronous reset; a random phase finishes.
// -----------------------------------------------------------------------------
module tb_johnson_monitor;

    localparam int W   = 4;
    localparam int NPH = 2 * W;
    localparam int LC  = 8;

    logic            clk;
    logic            rst;
    logic            en;
    logic [W-1:0]    q_in;
    logic            clr_err;
    logic [NPH-1:0]  phase_onehot;
    logic [2:0]      phase_idx;
    logic            phase_valid;
    logic            wrap_pulse;
    logic            locked;
    logic            err_pulse;
    logic            err_sticky;
    logic [7:0]      err_count;

    johnson_monitor #(
        .WIDTH      (W),
        .LOCK_CYCLES(LC),
        .ERR_CNT_W  (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .q_in        (q_in),
        .clr_err     (clr_err),
        .phase_onehot(phase_onehot),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .wrap_pulse  (wrap_pulse),
        .locked      (locked),
        .err_pulse   (err_pulse),
        .err_sticky  (err_sticky),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // ---------------------------------------------------------------------
    // Reference model (index level)
    // ---------------------------------------------------------------------
    int        m_prev_idx;
    bit        m_prev_ok;
    int        m_run;
    bit        m_locked;
    bit        m_sticky;
    int        m_count;
    int        m_idx;
    bit        m_valid;
    bit [7:0]  m_onehot;
    bit        m_wrap;
    bit        m_err;

    function automatic logic [W-1:0] code_of(input int k);
        int v;
        if (k <= W) v = ((1 << k) - 1) << (W - k);
        else        v = (1 << (NPH - k)) - 1;
        return v[W-1:0];
    endfunction

    function automatic int find_idx(input logic [W-1:0] q);
        for (int k = 0; k < NPH; k++) if (code_of(k) == q) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_prev_idx = 0; m_prev_ok = 0; m_run = 0; m_locked = 0;
        m_sticky = 0; m_count = 0; m_idx = 0; m_valid = 0;
        m_onehot = '0; m_wrap = 0; m_err = 0;
    endtask

    task automatic model_step(input bit e, input logic [W-1:0] q, input bit clr);
        int  idx;
        bit  legal, good, err;
        idx = find_idx(q);
        legal = (idx >= 0);
        good = 0;
        err  = 0;
        if (e) begin
            if (m_prev_ok && legal && idx == (m_prev_idx + 1) % NPH) good = 1;
            err = !legal || (m_prev_ok && !good);
            if (legal) begin
                m_idx = idx; m_valid = 1; m_onehot = 8'(1 << idx);
            end else begin
                m_valid = 0; m_onehot = '0;
            end
        end
        m_wrap = e && good && idx == 0;
        m_err  = err;
        if (err) begin
            m_run = 0; m_locked = 0;
        end else if (good && !m_locked) begin
            m_run++;
            if (m_run >= LC) m_locked = 1;
        end
        if (err) begin
            m_sticky = 1;
            m_count  = clr ? 1 : (m_count < 255 ? m_count + 1 : 255);
        end else if (clr) begin
            m_sticky = 0; m_count = 0;
        end
        if (e) begin
            m_prev_ok = legal; m_prev_idx = idx;
        end else begin
            m_prev_ok = 0;
        end
    endtask

    task automatic compare_all();
        check("phase_onehot", 32'(phase_onehot), 32'(m_onehot));
        check("phase_idx",    32'(phase_idx),    32'(m_idx));
        check("phase_valid",  32'(phase_valid),  32'(m_valid));
        check("wrap_pulse",   32'(wrap_pulse),   32'(m_wrap));
        check("locked",       32'(locked),       32'(m_locked));
        check("err_pulse",    32'(err_pulse),    32'(m_err));
        check("err_sticky",   32'(err_sticky),   32'(m_sticky));
        check("err_count",    32'(err_count),    32'(m_count));
    endtask

    // Drive one cycle, update the model, sample 1 ns after the edge.
    task automatic cycle(input bit e, input logic [W-1:0] q, input bit clr);
        en = e; q_in = q; clr_err = clr;
        @(posedge clk);
        model_step(e, q, clr);
        #1;
        compare_all();
    endtask

    // ---------------------------------------------------------------------
    // Start-up table
    // ---------------------------------------------------------------------
    typedef struct {
        logic [W-1:0] q;
        int           exp_idx;
        bit           exp_wrap;
        bit           exp_locked;
    } vec_t;

    vec_t tbl[16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'b0000, 0, 1'b0, 1'b0};
        tbl[1]  = '{4'b1000, 1, 1'b0, 1'b0};
        tbl[2]  = '{4'b1100, 2, 1'b0, 1'b0};
        tbl[3]  = '{4'b1110, 3, 1'b0, 1'b0};
        tbl[4]  = '{4'b1111, 4, 1'b0, 1'b0};
        tbl[5]  = '{4'b0111, 5, 1'b0, 1'b0};
        tbl[6]  = '{4'b0011, 6, 1'b0, 1'b0};
        tbl[7]  = '{4'b0001, 7, 1'b0, 1'b0};
        tbl[8]  = '{4'b0000, 0, 1'b1, 1'b1};
        tbl[9]  = '{4'b1000, 1, 1'b0, 1'b1};
        tbl[10] = '{4'b1100, 2, 1'b0, 1'b1};
        tbl[11] = '{4'b1110, 3, 1'b0, 1'b1};
        tbl[12] = '{4'b1111, 4, 1'b0, 1'b1};
        tbl[13] = '{4'b0111, 5, 1'b0, 1'b1};
        tbl[14] = '{4'b0011, 6, 1'b0, 1'b1};
        tbl[15] = '{4'b0001, 7, 1'b0, 1'b1};

        rst = 1'b0; en = 1'b0; q_in = '0; clr_err = 1'b0;
        model_reset();
        #12;
        compare_all();
        check("reset_locked", 32'(locked), 32'd0);
        check("reset_count",  32'(err_count), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Clean start-up: two passes through the sequence.
        for (int i = 0; i < 16; i++) begin
            cycle(1, tbl[i].q, 0);
            check("tbl_idx",    32'(phase_idx),    32'(tbl[i].exp_idx));
            check("tbl_onehot", 32'(phase_onehot), 32'(1) << tbl[i].exp_idx);
            check("tbl_valid",  32'(phase_valid),  32'd1);
            check("tbl_wrap",   32'(wrap_pulse),   32'(tbl[i].exp_wrap));
            check("tbl_locked", 32'(locked),       32'(tbl[i].exp_locked));
            check("tbl_err",    32'(err_pulse),    32'd0);
            check("tbl_count",  32'(err_count),    32'd0);
        end

        // Illegal code while locked.
        cycle(1, 4'b0101, 0);
        check("ill_err",    32'(err_pulse),    32'd1);
        check("ill_valid",  32'(phase_valid),  32'd0);
        check("ill_onehot", 32'(phase_onehot), 32'd0);
        check("ill_idx",    32'(phase_idx),    32'd7);
        check("ill_locked", 32'(locked),       32'd0);
        check("ill_sticky", 32'(err_sticky),   32'd1);
        check("ill_count",  32'(err_count),    32'd1);
        cycle(1, 4'b0000, 0);
        check("ill_pulse_end", 32'(err_pulse), 32'd0);
        for (int k = 1; k < NPH; k++) cycle(1, code_of(k), 0);
        check("relock_early", 32'(locked), 32'd0);
        cycle(1, 4'b0000, 0);
        check("relock", 32'(locked), 32'd1);

        // Legal but wrong step, then a stall.
        cycle(1, 4'b1000, 0);
        cycle(1, 4'b1100, 0);
        cycle(1, 4'b0011, 0);
        check("skip_err",    32'(err_pulse),   32'd1);
        check("skip_valid",  32'(phase_valid), 32'd1);
        check("skip_idx",    32'(phase_idx),   32'd6);
        check("skip_locked", 32'(locked),      32'd0);
        check("skip_count",  32'(err_count),   32'd2);
        cycle(1, 4'b1110, 0);
        check("skip2_err", 32'(err_pulse), 32'd1);
        cycle(1, 4'b1110, 0);
        check("stall_err",   32'(err_pulse), 32'd1);
        check("stall_count", 32'(err_count), 32'd4);

        // Lock again from index 3, then an enable gap.
        for (int k = 4; k < 12; k++) cycle(1, code_of(k % NPH), 0);
        check("gap_pre_locked", 32'(locked), 32'd1);
        for (int g = 0; g < 3; g++) begin
            cycle(0, 4'(g * 5), 0);
            check("gap_locked", 32'(locked),    32'd1);
            check("gap_err",    32'(err_pulse), 32'd0);
            check("gap_idx",    32'(phase_idx), 32'd3);
        end
        cycle(1, 4'b0011, 0);
        check("gap_resume_err",    32'(err_pulse), 32'd0);
        check("gap_resume_locked", 32'(locked),    32'd1);
        check("gap_resume_idx",    32'(phase_idx), 32'd6);
        cycle(1, 4'b0001, 0);
        check("gap_next_err", 32'(err_pulse), 32'd0);

        // Saturation and clear.
        for (int i = 0; i < 300; i++) cycle(1, 4'b0101, 0);
        check("sat_count",  32'(err_count),  32'd255);
        check("sat_sticky", 32'(err_sticky), 32'd1);
        cycle(0, 4'b0000, 1);
        check("clr_count",  32'(err_count),  32'd0);
        check("clr_sticky", 32'(err_sticky), 32'd0);
        cycle(1, 4'b1001, 1);
        check("clr_err_count",  32'(err_count),  32'd1);
        check("clr_err_sticky", 32'(err_sticky), 32'd1);

        // Asynchronous reset between edges.
        cycle(1, 4'b1100, 0);
        cycle(1, 4'b1110, 0);
        cycle(1, 4'b1111, 0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("arst_count",  32'(err_count),    32'd0);
        check("arst_onehot", 32'(phase_onehot), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cycle(1, 4'b0000, 0);
        check("post_rst_wrap", 32'(wrap_pulse), 32'd0);
        check("post_rst_err",  32'(err_pulse),  32'd0);
        check("post_rst_idx",  32'(phase_idx),  32'd0);
        cycle(1, 4'b1000, 0);
        check("post_rst_step", 32'(err_pulse), 32'd0);

        // Random phase against the model.
        for (int i = 0; i < 2000; i++) begin
            int           r, sel;
            logic [W-1:0] q;
            r   = $urandom_range(0, 99);
            sel = $urandom_range(0, 99);
            if (sel < 70 && m_prev_ok) q = code_of((m_prev_idx + 1) % NPH);
            else if (sel < 85)         q = code_of($urandom_range(0, NPH - 1));
            else                       q = 4'($urandom_range(0, 15));
            cycle(r < 85, q, $urandom_range(0, 19) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
